hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-003 MD_START  input  1  one-cycle pulse: a mult/multu/div/divu has been issued to multdiv_32.
REQ-004 MULTWRITE  input  1  multdiv_32 multiply result valid.
REQ-005 DIVWRITE  input  1  multdiv_32 divide result valid.
REQ-006 MD_HI  input  32  multdiv_32 ALU_HI result.
REQ-007 MD_LO  input  32  multdiv_32 ALU_LO result.
REQ-008 MTHI  input  1  move-to-HI request.
REQ-009 MTLO  input  1  move-to-LO request.
REQ-010 MT_DATA  input  32  source operand for MTHI/MTLO.
REQ-011 MFHI  input  1  move-from-HI request.
REQ-012 MFLO  input  1  move-from-LO request.
REQ-013 MD_RUN  output  1  drives multdiv_32 rst pin; 1 = run, 0 = hold multdiv_32 in reset.
REQ-014 HILO_STALL  output  1  combinational; 1 = pipeline holds the current HI/LO instruction.
REQ-015 RD_DATA  output  32  registered MFHI/MFLO result.
REQ-016 RD_VALID  output  1  registered; 1 for one cycle when RD_DATA is updated.
REQ-017 HI, LO  output  32 each  architectural HI/LO register contents.
REQ-018 TIMEOUT  output  1  sticky error flag: no multdiv result within the limit.

Function
REQ-019 FSM has two states, IDLE and WAIT; reset state is IDLE.
REQ-020 IDLE with MD_START=1: next state WAIT, MD_RUN=1 from the next cycle, wait counter=0, TIMEOUT cleared.
REQ-021 WAIT: wait counter increments each cycle; MD_RUN stays 1.
REQ-022 WAIT with MULTWRITE=1 or DIVWRITE=1: on that edge HI<=MD_HI, LO<=MD_LO, MD_RUN<=0, state<=IDLE; if both are 1, commit once.
REQ-023 WAIT with counter reaching 63 and no write: state<=IDLE, MD_RUN<=0, TIMEOUT<=1, HI/LO unchanged.
REQ-024 MD_START during WAIT is ignored; the in-flight op completes and commits.
REQ-025 MULTWRITE/DIVWRITE in IDLE are ignored (no HI/LO change).
REQ-026 HILO_STALL = (state==WAIT) AND (MFHI|MFLO|MTHI|MTLO); the stalled request has no effect that cycle.
REQ-027 Not stalled: MTHI writes HI<=MT_DATA; MTLO writes LO<=MT_DATA; both may occur in the same cycle.
REQ-028 Not stalled: MFHI gives RD_DATA<=HI; MFLO gives RD_DATA<=LO; RD_VALID<=1 next cycle; otherwise RD_VALID<=0 and RD_DATA holds.
REQ-029 MFHI and MFLO together: HI takes priority.
REQ-030 MFx and MTx to the same register in one cycle: RD_DATA returns the pre-write value.
REQ-031 MD_START and MTx in the same IDLE cycle: MTx writes first; the later multdiv commit overwrites.

Reset
REQ-032 rst=0 asynchronously sets state=IDLE, counter=0, HI=0, LO=0, RD_DATA=0, RD_VALID=0, MD_RUN=0, TIMEOUT=0.
REQ-033 Reset during WAIT abandons the op: MD_RUN=0 immediately, and a late MULTWRITE/DIVWRITE after release is ignored.

Verification
REQ-034 multu 4x5: MD_START, MULTWRITE with MD_HI=0, MD_LO=20 -> HI=0x00000000, LO=0x00000014, MD_RUN falls the same edge.
REQ-035 mult -4x5 then div -7/2: HI=0xFFFFFFFF, LO=0xFFFFFFEC; then HI=0xFFFFFFFF, LO=0xFFFFFFFD after DIVWRITE.
REQ-036 divu 7/2 with MFLO held from MD_START: HILO_STALL=1 until the DIVWRITE edge; next cycle RD_DATA=0x00000003, RD_VALID=1.
REQ-037 MTHI 0x12345678 with MFHI in the same cycle, IDLE, HI=0: RD_DATA=0x00000000; HI=0x12345678 afterwards.
REQ-038 MD_START, no write for 63 cycles: TIMEOUT=1, MD_RUN=0, state IDLE, HI/LO unchanged; next MD_START clears TIMEOUT.
REQ-039 rst=0 pulsed mid-WAIT, then MULTWRITE: all outputs 0 immediately; HI/LO remain 0 after release.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register file with multdiv_32 handshake, hazard stall and timeout.
// A multdiv operation is launched from IDLE and committed (or abandoned on
// timeout) from WAIT; MFHI/MFLO/MTHI/MTLO are held off while an op is in flight.
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MD_START,
    input  logic        MULTWRITE,
    input  logic        DIVWRITE,
    input  logic [31:0] MD_HI,
    input  logic [31:0] MD_LO,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] MT_DATA,
    input  logic        MFHI,
    input  logic        MFLO,
    output logic        MD_RUN,
    output logic        HILO_STALL,
    output logic [31:0] RD_DATA,
    output logic        RD_VALID,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        TIMEOUT
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    // Count value during the last tolerated WAIT cycle; the counter reaches 63 on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(62);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               timeout_d;
    logic               md_run_d;
    logic               commit;
    logic               md_write;
    logic               mf_req;
    logic [DATA_W-1:0]  rd_sel;

    assign md_write = MULTWRITE | DIVWRITE;
    assign mf_req   = MFHI | MFLO;
    // HI wins when both move-froms are requested together.
    assign rd_sel   = MFHI ? HI : LO;

    // Hazard stall: any HI/LO access waits while a multdiv op is in flight.
    assign HILO_STALL = (state_q == ST_WAIT) && (mf_req | MTHI | MTLO);

    // Next-state, wait counter and timeout decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = TIMEOUT;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MD_START) begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (md_write) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        md_run_d = (state_d == ST_WAIT);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            MD_RUN  <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            MD_RUN  <= md_run_d;
            TIMEOUT <= timeout_d;
        end
    end

    // Architectural HI/LO: multdiv commit, otherwise unstalled move-to writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            HI <= MD_HI;
            LO <= MD_LO;
        end else if (!HILO_STALL) begin
            if (MTHI) begin
                HI <= MT_DATA;
            end
            if (MTLO) begin
                LO <= MT_DATA;
            end
        end
    end

    // Move-from read port; samples HI/LO before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            if (mf_req && !HILO_STALL) begin
                RD_DATA  <= rd_sel;
                RD_VALID <= 1'b1;
            end
        end
    end

endmodule
